// File: rtl/gate_bist_checker.sv
// Exhaustive-vector BIST engine for single-output basic gates: drives {b,a}
// vectors, waits a settle time, samples the gate output and reports mismatches.
//
// state  | meaning
// IDLE   | stimulus parked at 0, waiting for start
// SETTLE | vector driven, counting down the settle time
// SAMPLE | compare dut_y against the selected truth table, advance vector
// DONE   | one-cycle result cycle, done pulsed
module gate_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       gate_sel,
  input  logic             dut_y,
  output logic             stim_a,
  output logic             stim_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       sel_q;
  logic [1:0]       idx;
  logic [CNT_W-1:0] cnt;

  logic             two_input;
  logic             last_vec;
  logic             expected;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
  logic [1:0]       idx_next;

  function automatic logic gate_fn(input logic [2:0] sel, input logic a, input logic b);
    logic y;
    case (sel)
      3'd0:    y = ~a;
      3'd1:    y = a & b;
      3'd2:    y = a | b;
      3'd3:    y = ~(a & b);
      3'd4:    y = ~(a | b);
      3'd5:    y = a ^ b;
      3'd6:    y = ~(a ^ b);
      default: y = a;
    endcase
    return y;
  endfunction

  // NOT and BUF only use input a, so they get a 2-vector sweep
  always_comb begin
    two_input = (sel_q != 3'd0) && (sel_q != 3'd7);
    last_vec  = two_input ? (idx == 2'd3) : (idx == 2'd1);
    expected  = gate_fn(sel_q, stim_a, stim_b);
    mismatch  = (expected != dut_y);
    idx_next  = idx + 2'd1;
    err_next  = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + ERR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sel_q          <= 3'd0;
      idx            <= 2'd0;
      cnt            <= '0;
      stim_a         <= 1'b0;
      stim_b         <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          done   <= 1'b0;
          stim_a <= 1'b0;
          stim_b <= 1'b0;
          if (start) begin
            sel_q          <= gate_sel;
            err_count      <= '0;
            first_fail_vec <= 2'b00;
            pass           <= 1'b0;
            idx            <= 2'd0;
            cnt            <= CNT_LOAD;
            busy           <= 1'b1;
            state          <= SETTLE;
          end
        end

        SETTLE: begin
          if (cnt == '0) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        SAMPLE: begin
          err_count <= err_next;
          // err_count is still zero only before the first mismatch of the run
          if (mismatch && (err_count == '0)) begin
            first_fail_vec <= {stim_b, stim_a};
          end
          if (last_vec) begin
            stim_a <= 1'b0;
            stim_b <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
            pass   <= (err_next == '0);
            state  <= DONE;
          end else begin
            idx    <= idx_next;
            stim_a <= idx_next[0];
            stim_b <= idx_next[1] & two_input;
            cnt    <= CNT_LOAD;
            state  <= SETTLE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: table of gate/fault runs with
// hand-computed results, plus sequences for saturation, mid-run start and reset.
module tb_gate_bist_checker;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [2:0] gate_sel;
  logic dut_y;
  logic stim_a, stim_b, busy, done, pass;
  logic [7:0] err_count;
  logic [1:0] first_fail_vec;

  logic start2;
  logic [2:0] gate_sel2;
  logic dut_y2;
  logic stim_a2, stim_b2, busy2, done2, pass2;
  logic [1:0] err_count2;
  logic [1:0] first_fail_vec2;

  // behaviour of the gate sitting under test
  logic [2:0] dfn;
  logic dinv, dstuck;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic real_gate(input logic [2:0] f, input logic a, input logic b);
    case (f)
      3'd0: return ~a;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  assign dut_y  = dstuck ? 1'b1 : (dinv ^ real_gate(dfn, stim_a, stim_b));
  assign dut_y2 = stim_a2 ^ stim_b2;  // inverted XNOR

  gate_bist_checker #(.SETTLE_CYCLES(S), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .gate_sel(gate_sel), .dut_y(dut_y),
    .stim_a(stim_a), .stim_b(stim_b), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_vec(first_fail_vec)
  );

  gate_bist_checker #(.SETTLE_CYCLES(S), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .gate_sel(gate_sel2), .dut_y(dut_y2),
    .stim_a(stim_a2), .stim_b(stim_b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err_count2), .first_fail_vec(first_fail_vec2)
  );

  typedef struct {
    logic [2:0] sel;
    logic [2:0] fn;
    logic       inv;
    logic       stuck;
    int         len;
    logic [7:0] err;
    logic [1:0] ffv;
    logic       pass;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic run(input int i, input bit start_at_done);
    int e;
    int k;
    bit seen;
    bit two;
    dfn    = tbl[i].fn;
    dinv   = tbl[i].inv;
    dstuck = tbl[i].stuck;
    two    = (tbl[i].sel != 3'd0) && (tbl[i].sel != 3'd7);
    @(negedge clk);
    gate_sel = tbl[i].sel;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e    = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        k = e / (S + 1);
        check("stim_a", 32'(stim_a), 32'(k % 2));
        check("stim_b", 32'(stim_b), two ? 32'(k / 2) : 32'd0);
        check("busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        e++;
      end
    end
    check("run_len", 32'(e), 32'(tbl[i].len));
    check("pass", 32'(pass), 32'(tbl[i].pass));
    check("err_count", 32'(err_count), 32'(tbl[i].err));
    check("first_fail_vec", 32'(first_fail_vec), 32'(tbl[i].ffv));
    check("stim_idle_at_done", 32'({stim_b, stim_a}), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    if (start_at_done) start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("pass_held", 32'(pass), 32'(tbl[i].pass));
    check("err_held", 32'(err_count), 32'(tbl[i].err));
    if (start_at_done) begin
      @(posedge clk);
      #1;
      check("start_in_done_ignored", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int e;
    bit seen;
    bit stray_done;

    //            sel   dut fn inv   stuck len err    ffv    pass
    tbl[0] = '{3'd0, 3'd0, 1'b0, 1'b0, 6,  8'd0, 2'b00, 1'b1}; // NOT ok
    tbl[1] = '{3'd1, 3'd1, 1'b0, 1'b0, 12, 8'd0, 2'b00, 1'b1}; // AND ok
    tbl[2] = '{3'd0, 3'd0, 1'b0, 1'b1, 6,  8'd1, 2'b01, 1'b0}; // NOT stuck-1
    tbl[3] = '{3'd5, 3'd2, 1'b0, 1'b0, 12, 8'd1, 2'b11, 1'b0}; // XOR vs OR
    tbl[4] = '{3'd5, 3'd5, 1'b0, 1'b0, 12, 8'd0, 2'b00, 1'b1}; // XOR ok rerun
    tbl[5] = '{3'd7, 3'd7, 1'b0, 1'b1, 6,  8'd1, 2'b00, 1'b0}; // BUF stuck-1
    tbl[6] = '{3'd3, 3'd3, 1'b1, 1'b0, 12, 8'd4, 2'b00, 1'b0}; // NAND inverted
    tbl[7] = '{3'd4, 3'd4, 1'b0, 1'b0, 12, 8'd0, 2'b00, 1'b1}; // NOR ok
    tbl[8] = '{3'd1, 3'd2, 1'b0, 1'b0, 12, 8'd2, 2'b01, 1'b0}; // AND vs OR
    tbl[9] = '{3'd6, 3'd6, 1'b0, 1'b0, 12, 8'd0, 2'b00, 1'b1}; // XNOR ok

    rst_n = 1'b0; start = 1'b0; gate_sel = 3'd0; start2 = 1'b0; gate_sel2 = 3'd0;
    dfn = 3'd0; dinv = 1'b0; dstuck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", 32'({stim_a, stim_b, busy, done, pass}), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_ffv", 32'(first_fail_vec), 32'd0);
    check("rst_sat_outputs", 32'({stim_a2, stim_b2, busy2, done2, pass2, err_count2, first_fail_vec2}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run(i, (i == 1) || (i == 6));
    end

    // ERR_W=2 saturation with start held and gate_sel toggled mid-run
    @(negedge clk);
    gate_sel2 = 3'd6;
    start2    = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    e = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      if (done2) begin
        seen = 1'b1;
      end else begin
        if (e == 2) begin
          start2    = 1'b1;
          gate_sel2 = 3'd0;
        end
        if (e == 9) start2 = 1'b0;
        if (e == 7) check("sat_vec2_stim_b", 32'({stim_b2, stim_a2}), 32'd2);
        @(posedge clk);
        #1;
        e++;
      end
    end
    check("sat_run_len", 32'(e), 32'd12);
    check("sat_err_count", 32'(err_count2), 32'd3);
    check("sat_ffv", 32'(first_fail_vec2), 32'd0);
    check("sat_pass", 32'(pass2), 32'd0);
    gate_sel2 = 3'd6;

    // asynchronous reset during SETTLE of vector 2 (AND checked against an OR gate)
    dfn = 3'd2; dinv = 1'b0; dstuck = 1'b0;
    @(negedge clk);
    gate_sel = 3'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("pre_rst_vec", 32'({stim_b, stim_a}), 32'd2);
    check("pre_rst_err", 32'(err_count), 32'd1);
    check("pre_rst_ffv", 32'(first_fail_vec), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({stim_a, stim_b, busy, done, pass}), 32'd0);
    check("async_rst_err", 32'(err_count), 32'd0);
    check("async_rst_ffv", 32'(first_fail_vec), 32'd0);
    stray_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      stray_done |= done;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (16) begin
      @(posedge clk);
      #1;
      stray_done |= done | busy;
    end
    check("no_done_after_rst", 32'(stray_done), 32'd0);
    run(3, 1'b0);
    run(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
